// File: rtl/hex_pair_decoder.sv
// Seven-segment pair decoder and up-count sequence monitor for an 8-bit counter display.
// Optional Steps counter is built only when HEX_PAIR_STEP_COUNT_EN is defined.
module hex_pair_decoder #(
   parameter int STABLE_N       = 2,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter int STEP_W         = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Sample,
   input  logic [6:0]        HEX0_in,
   input  logic [6:0]        HEX1_in,
   input  logic              Rearm,
   output logic [7:0]        Value,
   output logic              Valid,
   output logic              BadPattern,
   output logic              Changed,
   output logic              SeqError,
   output logic [1:0]        State,
   output logic [STEP_W-1:0] Steps
);

   localparam int RUN_W = $clog2(STABLE_N + 1);
   localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(STABLE_N);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [7:0]       value_reg, value_next;
   logic             valid_reg, valid_next;
   logic             bad_reg, bad_next;
   logic             changed_reg, changed_next;
   logic             seq_err_reg, seq_err_next;
   logic [7:0]       cand_reg, cand_next;
   logic [RUN_W-1:0] run_reg, run_next;
   logic [RUN_W-1:0] run_inc;
   logic [4:0]       lo_dec, hi_dec;
   logic [7:0]       pair;
   logic             pair_ok;
   logic             accept;

   // Returns {known, nibble}; patterns are always looked up in lit-low form.
   function automatic logic [4:0] seg_decode(input logic [6:0] pat);
      logic [4:0] r;
      case (pat)
         7'h40:   r = 5'h10;
         7'h79:   r = 5'h11;
         7'h24:   r = 5'h12;
         7'h30:   r = 5'h13;
         7'h19:   r = 5'h14;
         7'h12:   r = 5'h15;
         7'h02:   r = 5'h16;
         7'h78:   r = 5'h17;
         7'h00:   r = 5'h18;
         7'h18:   r = 5'h19;
         7'h08:   r = 5'h1A;
         7'h03:   r = 5'h1B;
         7'h46:   r = 5'h1C;
         7'h21:   r = 5'h1D;
         7'h06:   r = 5'h1E;
         7'h0E:   r = 5'h1F;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   assign lo_dec  = seg_decode(SEG_ACTIVE_LOW ? HEX0_in : ~HEX0_in);
   assign hi_dec  = seg_decode(SEG_ACTIVE_LOW ? HEX1_in : ~HEX1_in);
   assign pair    = {hi_dec[3:0], lo_dec[3:0]};
   assign pair_ok = hi_dec[4] & lo_dec[4];
   assign run_inc = run_reg + 1'b1;

`ifdef HEX_PAIR_STEP_COUNT_EN
   logic              step_inc;
   logic [STEP_W-1:0] steps_reg;
`endif

   always_comb begin
      state_next   = state_reg;
      value_next   = value_reg;
      valid_next   = valid_reg;
      bad_next     = 1'b0;
      changed_next = 1'b0;
      seq_err_next = seq_err_reg;
      cand_next    = cand_reg;
      run_next     = run_reg;
      accept       = 1'b0;
`ifdef HEX_PAIR_STEP_COUNT_EN
      step_inc     = 1'b0;
`endif
      if (Rearm) begin
         state_next   = IDLE;
         seq_err_next = 1'b0;
         run_next     = '0;
      end else if (Sample) begin
         if (!pair_ok) begin
            bad_next = 1'b1;
            run_next = '0;
         end else if (run_reg != '0 && pair == cand_reg) begin
            // Once full the run parks, so a steady display is accepted only once.
            if (run_reg != RUN_FULL) begin
               run_next = run_inc;
               accept   = (run_inc == RUN_FULL);
            end
         end else begin
            cand_next = pair;
            run_next  = RUN_W'(1);
            accept    = (RUN_FULL == RUN_W'(1));
         end
      end

      if (accept) begin
         case (state_reg)
            IDLE: begin
               value_next   = pair;
               valid_next   = 1'b1;
               changed_next = 1'b1;
               state_next   = TRACK;
            end
            TRACK: begin
               if (pair == value_reg) begin
                  changed_next = 1'b0;
               end else if (pair == value_reg + 8'd1) begin
                  value_next   = pair;
                  changed_next = 1'b1;
`ifdef HEX_PAIR_STEP_COUNT_EN
                  step_inc     = 1'b1;
`endif
               end else if (pair == 8'h00) begin
                  value_next   = pair;
                  changed_next = 1'b1;
               end else begin
                  value_next   = pair;
                  changed_next = 1'b1;
                  seq_err_next = 1'b1;
                  state_next   = FAULT;
               end
            end
            default: begin
               value_next   = pair;
               changed_next = (pair != value_reg);
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_reg   <= IDLE;
         value_reg   <= '0;
         valid_reg   <= 1'b0;
         bad_reg     <= 1'b0;
         changed_reg <= 1'b0;
         seq_err_reg <= 1'b0;
         cand_reg    <= '0;
         run_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         value_reg   <= value_next;
         valid_reg   <= valid_next;
         bad_reg     <= bad_next;
         changed_reg <= changed_next;
         seq_err_reg <= seq_err_next;
         cand_reg    <= cand_next;
         run_reg     <= run_next;
      end
   end

`ifdef HEX_PAIR_STEP_COUNT_EN
   always_ff @(posedge Clk) begin
      if (Reset) begin
         steps_reg <= '0;
      end else if (step_inc && steps_reg != '1) begin
         steps_reg <= steps_reg + 1'b1;
      end
   end
   assign Steps = steps_reg;
`else
   assign Steps = '0;
`endif

   assign Value      = value_reg;
   assign Valid      = valid_reg;
   assign BadPattern = bad_reg;
   assign Changed    = changed_reg;
   assign SeqError   = seq_err_reg;
   assign State      = state_reg;

endmodule

// File: tb/tb_hex_pair_decoder.sv
// Directed bench for hex_pair_decoder: one vector per clock, checked after the edge,
// followed by a hand-written reset-during-run sequence.
module tb_hex_pair_decoder;

   localparam int STEP_W = 16;
`ifdef HEX_PAIR_STEP_COUNT_EN
   localparam bit STEP_EN = 1'b1;
`else
   localparam bit STEP_EN = 1'b0;
`endif

   logic              Clk = 1'b0;
   logic              Reset;
   logic              Sample;
   logic [6:0]        HEX0_in;
   logic [6:0]        HEX1_in;
   logic              Rearm;
   logic [7:0]        Value;
   logic              Valid;
   logic              BadPattern;
   logic              Changed;
   logic              SeqError;
   logic [1:0]        State;
   logic [STEP_W-1:0] Steps;

   int tests_run = 0;
   int tests_failed = 0;

   hex_pair_decoder #(.STABLE_N(2), .SEG_ACTIVE_LOW(1'b1), .STEP_W(STEP_W)) dut (
      .Clk(Clk), .Reset(Reset), .Sample(Sample), .HEX0_in(HEX0_in), .HEX1_in(HEX1_in),
      .Rearm(Rearm), .Value(Value), .Valid(Valid), .BadPattern(BadPattern),
      .Changed(Changed), .SeqError(SeqError), .State(State), .Steps(Steps)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      bit         s;
      bit         r;
      logic [6:0] h1;
      logic [6:0] h0;
      logic [7:0] v;
      bit         vl;
      bit         ch;
      bit         bd;
      bit         se;
      logic [1:0] st;
      int         stp;
   } vec_t;

   function automatic vec_t mk(bit s, bit r, logic [6:0] h1, logic [6:0] h0, logic [7:0] v,
                               bit vl, bit ch, bit bd, bit se, logic [1:0] st, int stp);
      vec_t x;
      x.s = s; x.r = r; x.h1 = h1; x.h0 = h0; x.v = v; x.vl = vl; x.ch = ch;
      x.bd = bd; x.se = se; x.st = st; x.stp = stp;
      return x;
   endfunction

   task automatic check(string name, logic [7:0] v, bit vl, bit ch, bit bd, bit se,
                        logic [1:0] st, int stp);
      logic [STEP_W-1:0] exp_steps;
      logic [29:0]       act, exp;
      exp_steps = STEP_EN ? STEP_W'(stp) : '0;
      act = {Value, Valid, Changed, BadPattern, SeqError, State, Steps};
      exp = {v, vl, ch, bd, se, st, exp_steps};
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got Value=%h Valid=%b Changed=%b Bad=%b SeqErr=%b State=%0d Steps=%0d, expected Value=%h Valid=%b Changed=%b Bad=%b SeqErr=%b State=%0d Steps=%0d",
                  name, Value, Valid, Changed, BadPattern, SeqError, State, Steps,
                  v, vl, ch, bd, se, st, exp_steps);
      end else begin
         $display("[TB] %s ok: Value=%h State=%0d Steps=%0d", name, Value, State, Steps);
      end
   endtask

   vec_t vecs[$];

   initial begin
      // Active-low codes: 0=40 1=79 2=24 3=30 4=19 5=12 F=0E
      vecs.push_back(mk(1,0,7'h40,7'h40, 8'h00,0,0,0,0,0,0));  // run 1
      vecs.push_back(mk(1,0,7'h40,7'h40, 8'h00,1,1,0,0,1,0));  // first load
      vecs.push_back(mk(1,0,7'h40,7'h40, 8'h00,1,0,0,0,1,0));  // held, no re-accept
      vecs.push_back(mk(1,0,7'h40,7'h79, 8'h00,1,0,0,0,1,0));
      vecs.push_back(mk(1,0,7'h40,7'h79, 8'h01,1,1,0,0,1,1));  // legal step
      vecs.push_back(mk(1,0,7'h40,7'h30, 8'h01,1,0,0,0,1,1));
      vecs.push_back(mk(1,0,7'h40,7'h30, 8'h03,1,1,0,1,2,1));  // skip -> fault
      vecs.push_back(mk(0,1,7'h40,7'h40, 8'h03,1,0,0,0,0,1));  // rearm
      vecs.push_back(mk(1,0,7'h0E,7'h0E, 8'h03,1,0,0,0,0,1));
      vecs.push_back(mk(1,0,7'h0E,7'h0E, 8'hFF,1,1,0,0,1,1));
      vecs.push_back(mk(1,0,7'h40,7'h40, 8'hFF,1,0,0,0,1,1));
      vecs.push_back(mk(1,0,7'h40,7'h40, 8'h00,1,1,0,0,1,2));  // FF->00 wrap is a step
      vecs.push_back(mk(1,0,7'h40,7'h79, 8'h00,1,0,0,0,1,2));  // run 1
      vecs.push_back(mk(1,0,7'h40,7'h7F, 8'h00,1,0,1,0,1,2));  // bad pattern
      vecs.push_back(mk(1,0,7'h40,7'h79, 8'h00,1,0,0,0,1,2));  // run restarts at 1
      vecs.push_back(mk(1,0,7'h40,7'h79, 8'h01,1,1,0,0,1,3));
      vecs.push_back(mk(1,0,7'h40,7'h24, 8'h01,1,0,0,0,1,3));  // alternating 02/01
      vecs.push_back(mk(1,0,7'h40,7'h79, 8'h01,1,0,0,0,1,3));
      vecs.push_back(mk(1,0,7'h40,7'h24, 8'h01,1,0,0,0,1,3));
      vecs.push_back(mk(1,0,7'h40,7'h79, 8'h01,1,0,0,0,1,3));
      vecs.push_back(mk(1,0,7'h40,7'h24, 8'h01,1,0,0,0,1,3));
      vecs.push_back(mk(1,1,7'h40,7'h24, 8'h01,1,0,0,0,0,3));  // rearm wins over sample
      vecs.push_back(mk(1,0,7'h40,7'h24, 8'h01,1,0,0,0,0,3));  // run was cleared
      vecs.push_back(mk(1,0,7'h40,7'h24, 8'h02,1,1,0,0,1,3));  // IDLE load, no check
      vecs.push_back(mk(1,0,7'h40,7'h40, 8'h02,1,0,0,0,1,3));
      vecs.push_back(mk(1,0,7'h40,7'h40, 8'h00,1,1,0,0,1,3));  // clear, Steps kept
      vecs.push_back(mk(1,0,7'h40,7'h30, 8'h00,1,0,0,0,1,3));
      vecs.push_back(mk(1,0,7'h40,7'h30, 8'h03,1,1,0,1,2,3));  // fault again
      vecs.push_back(mk(1,0,7'h19,7'h19, 8'h03,1,0,0,1,2,3));
      vecs.push_back(mk(1,0,7'h19,7'h19, 8'h44,1,1,0,1,2,3));  // FAULT: value tracks
      vecs.push_back(mk(1,0,7'h19,7'h12, 8'h44,1,0,0,1,2,3));
      vecs.push_back(mk(1,0,7'h19,7'h12, 8'h45,1,1,0,1,2,3));  // Steps frozen in FAULT

      Reset = 1'b1; Sample = 1'b0; Rearm = 1'b0; HEX0_in = 7'h40; HEX1_in = 7'h40;
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      check("reset", 8'h00, 0, 0, 0, 0, 2'd0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         Sample  = vecs[i].s;
         Rearm   = vecs[i].r;
         HEX1_in = vecs[i].h1;
         HEX0_in = vecs[i].h0;
         @(negedge Clk);
         check($sformatf("vec%0d", i), vecs[i].v, vecs[i].vl, vecs[i].ch, vecs[i].bd,
               vecs[i].se, vecs[i].st, vecs[i].stp);
      end
      Sample = 1'b0; Rearm = 1'b0;
      @(negedge Clk);
      check("idle_no_pulse", 8'h45, 1, 0, 0, 1, 2'd2, 3);

      // Reset landing in the middle of a stability run.
      Sample = 1'b1; HEX1_in = 7'h40; HEX0_in = 7'h79;
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      check("reset_mid_run", 8'h00, 0, 0, 0, 0, 2'd0, 0);
      @(negedge Clk);
      check("post_reset_run1", 8'h00, 0, 0, 0, 0, 2'd0, 0);
      @(negedge Clk);
      check("post_reset_load", 8'h01, 1, 1, 0, 0, 2'd1, 0);
      Sample = 1'b0;
      @(negedge Clk);
      check("post_reset_hold", 8'h01, 1, 0, 0, 0, 2'd1, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
